// File: rtl/ysyx_23060203_exu_pkg.sv
// Shared encodings for the execute stage: operand selects, branch kinds,
// memory op kinds and the ALU function codes.
package ysyx_23060203_exu_pkg;

    localparam int EXU_XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SHL = 3'd1,
        ALU_LTS = 3'd2,
        ALU_LTU = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHR = 3'd5,
        ALU_OR  = 3'd6,
        ALU_AND = 3'd7
    } alu_funct_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_COND = 3'd1,
        BR_JAL  = 3'd2,
        BR_JALR = 3'd3
    } br_e;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'd0,
        ASEL_PC   = 2'd1,
        ASEL_ZERO = 2'd2
    } asel_e;

    typedef enum logic [1:0] {
        BSEL_RS2  = 2'd0,
        BSEL_IMM  = 2'd1,
        BSEL_FOUR = 2'd2
    } bsel_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_e;

    // Unconditional control transfer (always redirects, result is the link address)
    function automatic logic br_is_jump(input logic [2:0] br);
        return (br == BR_JAL) || (br == BR_JALR);
    endfunction

endpackage

// File: rtl/ysyx_23060203_exu_if.sv
// IDU->EXU request channel and EXU->LSU/WBU result channel.
// Both channels: a transfer happens on a rising edge where valid and ready are
// both 1; valid is never withdrawn while waiting for ready, and in_ready never
// depends on in_valid.
interface ysyx_23060203_exu_if;
    import ysyx_23060203_exu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [EXU_XLEN-1:0] in_pc;
    logic [EXU_XLEN-1:0] in_rs1;
    logic [EXU_XLEN-1:0] in_rs2;
    logic [EXU_XLEN-1:0] in_imm;
    logic [4:0]          in_rd;
    logic                in_rd_wen;
    logic [1:0]          in_asel;
    logic [1:0]          in_bsel;
    logic [2:0]          in_funct;
    logic                in_funcs;
    logic [2:0]          in_br;
    logic                in_br_inv;
    logic [1:0]          in_mem;
    logic [2:0]          in_mem_f3;

    logic                out_valid;
    logic                out_ready;
    logic [EXU_XLEN-1:0] out_pc;
    logic [EXU_XLEN-1:0] out_res;
    logic [EXU_XLEN-1:0] out_sdata;
    logic [4:0]          out_rd;
    logic                out_rd_wen;
    logic [1:0]          out_mem;
    logic [2:0]          out_mem_f3;

    // Environment side: produces requests, consumes results
    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_rd_wen,
               in_asel, in_bsel, in_funct, in_funcs, in_br, in_br_inv,
               in_mem, in_mem_f3, out_ready,
        input  in_ready, out_valid, out_pc, out_res, out_sdata, out_rd,
               out_rd_wen, out_mem, out_mem_f3
    );

    // Execute stage side
    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_imm, in_rd, in_rd_wen,
               in_asel, in_bsel, in_funct, in_funcs, in_br, in_br_inv,
               in_mem, in_mem_f3, out_ready,
        output in_ready, out_valid, out_pc, out_res, out_sdata, out_rd,
               out_rd_wen, out_mem, out_mem_f3
    );

endinterface

// File: rtl/ysyx_23060203_exu_alu.sv
// Combinational integer ALU. funcs selects SUB for ADD and SRA for SHR.
module ysyx_23060203_ALU
    import ysyx_23060203_exu_pkg::*;
#(
    parameter int XLEN = EXU_XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct,
    input  logic            funcs,
    output logic [XLEN-1:0] res
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    // Function decode; comparisons return 0/1 in bit 0
    always_comb begin
        res = '0;
        case (alu_funct_e'(funct))
            ALU_ADD: res = funcs ? (a - b) : (a + b);
            ALU_SHL: res = a << shamt;
            ALU_LTS: res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_LTU: res = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR: res = a ^ b;
            ALU_SHR: res = funcs ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            ALU_OR:  res = a | b;
            ALU_AND: res = a & b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_exu.sv
// Execute stage: operand muxes, ALU, branch resolution, one-entry result
// buffer, one-cycle PC redirect pulse and an output stall counter.
module ysyx_23060203_exu
    import ysyx_23060203_exu_pkg::*;
#(
    parameter int XLEN    = EXU_XLEN,
    parameter bit PERF_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    ysyx_23060203_exu_if.slave bus,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [31:0]        perf_stall
);

    logic            accept;
    logic            is_cond;
    logic            is_jump;
    logic            taken;
    logic            take_redirect;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] pc_imm;
    logic [XLEN-1:0] rs1_imm;
    logic [XLEN-1:0] pc_4;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;

    // The buffer can take a new entry when empty or when it drains this cycle
    assign bus.in_ready = !bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & !flush;

    // Operand selection; unused select codes feed zero
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (bus.in_asel)
            ASEL_RS1: op_a = bus.in_rs1;
            ASEL_PC:  op_a = bus.in_pc;
            default:  op_a = '0;
        endcase
        case (bus.in_bsel)
            BSEL_RS2:  op_b = bus.in_rs2;
            BSEL_IMM:  op_b = bus.in_imm;
            BSEL_FOUR: op_b = XLEN'(4);
            default:   op_b = '0;
        endcase
    end

    ysyx_23060203_ALU #(.XLEN(XLEN)) u_alu (
        .a     (op_a),
        .b     (op_b),
        .funct (bus.in_funct),
        .funcs (bus.in_funcs),
        .res   (alu_val)
    );

    // Dedicated adders so targets and link address do not compete for the ALU
    assign pc_imm  = bus.in_pc + bus.in_imm;
    assign rs1_imm = bus.in_rs1 + bus.in_imm;
    assign pc_4    = bus.in_pc + XLEN'(4);

    // Branch resolution; BEQ uses XOR with inversion, so zero means taken
    assign is_cond       = (bus.in_br == BR_COND);
    assign is_jump       = br_is_jump(bus.in_br);
    assign taken         = (alu_val != '0) ^ bus.in_br_inv;
    assign take_redirect = is_jump | (is_cond & taken);
    assign target        = (bus.in_br == BR_JALR) ? (rs1_imm & ~XLEN'(1)) : pc_imm;
    assign result        = is_jump ? pc_4 : alu_val;

    // Result buffer: load on accept, drain on out_ready, dropped on flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_valid  <= 1'b0;
            bus.out_pc     <= '0;
            bus.out_res    <= '0;
            bus.out_sdata  <= '0;
            bus.out_rd     <= '0;
            bus.out_rd_wen <= 1'b0;
            bus.out_mem    <= '0;
            bus.out_mem_f3 <= '0;
        end else begin
            if (flush) begin
                bus.out_valid <= 1'b0;
            end else if (accept) begin
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept) begin
                bus.out_pc     <= bus.in_pc;
                bus.out_res    <= result;
                bus.out_sdata  <= bus.in_rs2;
                bus.out_rd     <= bus.in_rd;
                bus.out_rd_wen <= bus.in_rd_wen & !is_cond;
                bus.out_mem    <= is_cond ? MEM_NONE : bus.in_mem;
                bus.out_mem_f3 <= bus.in_mem_f3;
            end
        end
    end

    // Redirect pulse for exactly one cycle after accepting a taken transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= accept & take_redirect;
            if (accept & take_redirect) begin
                redirect_pc <= target;
            end
        end
    end

    generate
        if (PERF_EN) begin : g_perf
            // Count cycles where a result waits on downstream; wraps naturally
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    perf_stall <= '0;
                end else if (bus.out_valid & !bus.out_ready) begin
                    perf_stall <= perf_stall + 32'd1;
                end
            end
        end else begin : g_no_perf
            assign perf_stall = 32'd0;
        end
    endgenerate

endmodule
